// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MD_* opcodes   3-bit operation codes presented on md_unit.op
//   DEF_*_CYCLES   default latencies for mult/multu and div/divu
//   is_md_instr()  recognises instructions that use the HI/LO unit,
//                  so control and stall logic can classify them
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    // SPECIAL-opcode function codes of the HI/LO instructions
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    // True for any instruction that reads or writes HI/LO (mfhi/mflo included,
    // since they must also wait for an in-flight operation).
    function automatic logic is_md_instr(input logic [31:0] instr);
        logic [5:0] opcode;
        logic [5:0] funct;
        opcode = instr[31:26];
        funct  = instr[5:0];
        if (opcode != 6'h00) begin
            return 1'b0;
        end
        return (funct == FUNCT_MFHI)  || (funct == FUNCT_MTHI)  ||
               (funct == FUNCT_MFLO)  || (funct == FUNCT_MTLO)  ||
               (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core of the multiply/divide unit.
//   op_i      MD_* opcode selecting signed/unsigned multiply or divide
//   a_i, b_i  operands (rs, rt)
//   res_hi_o  product[63:32] or remainder
//   res_lo_o  product[31:0]  or quotient
//   div0_o    set for div/divu with a zero divisor
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div0_o
);

    logic        sgn_mul;
    logic        sgn_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign sgn_mul = (op_i == MD_MULT);
    assign sgn_div = (op_i == MD_DIV);

    // A single 64x64 multiplier serves both forms: sign- or zero-extending the
    // operands makes the low 64 bits of the product correct either way.
    assign a_ext = {{32{sgn_mul & a_i[31]}}, a_i};
    assign b_ext = {{32{sgn_mul & b_i[31]}}, b_i};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: the quotient truncates toward
    // zero and the remainder follows the dividend. The magnitude of 0x80000000
    // is representable as unsigned, so the most-negative case needs no special path.
    assign a_neg = sgn_div & a_i[31];
    assign b_neg = sgn_div & b_i[31];
    assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_mag = b_neg ? (~b_i + 32'd1) : b_i;
    // Keep the divider defined when b is zero; the result is discarded anyway.
    assign den   = (b_i == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / den;
    assign r_mag = a_mag % den;
    assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
        div0_o   = 1'b0;
        case (op_i)
            MD_MULT, MD_MULTU: begin
                res_hi_o = prod[63:32];
                res_lo_o = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi_o = rem;
                res_lo_o = quot;
                div0_o   = (b_i == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit beside the E-stage ALU, holding HI/LO.
//   clk    clock
//   reset  synchronous active-high reset; clears all state and aborts any op
//   start  one-cycle pulse: the E-stage instruction is md-class
//   op     MD_* opcode, sampled only with start
//   A, B   forwarded rs / rt values
//   busy   start | countdown running (combinational, to the hazard unit)
//   hi/lo  committed HI/LO registers (mfhi/mflo sources)
// The result is computed at the start edge and parked in tmp; a countdown
// models the latency and copies tmp to hi/lo on its last step, so the new
// values appear N+1 cycles after the start cycle.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     tmp_hi_q, tmp_hi_d;
    logic [31:0]     tmp_lo_q, tmp_lo_d;
    logic            div0_q, div0_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic [31:0]     res_hi;
    logic [31:0]     res_lo;
    logic            res_div0;

    md_calc u_calc (
        .op_i     (op),
        .a_i      (A),
        .b_i      (B),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo),
        .div0_o   (res_div0)
    );

    always_comb begin
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (cnt_q != '0) begin
            // A start here is illegal and deliberately ignored.
            cnt_d = cnt_q - CntW'(1);
            if ((cnt_q == CntW'(1)) && !div0_q) begin
                hi_d = tmp_hi_q;
                lo_d = tmp_lo_q;
            end
        end else if (start) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    div0_d   = 1'b0;
                    cnt_d    = CntW'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    div0_d   = res_div0;
                    cnt_d    = CntW'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = start | (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
